// File: rtl/gates_pkg.sv
// gates_pkg: shared constants for the basic-gates library
package gates_pkg;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: activity counter that increments on inc and saturates at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // next count: hold once all-ones is reached
  always_comb cnt_d = (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  // reset clears the count and takes priority over increments
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/xor_gate_primitive.sv
// xor_gate_primitive: bitwise XOR with registered copy and saturating toggle counter
module xor_gate_primitive
  import gates_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out_q,
  output logic [CNT_W-1:0] tog_cnt
);
  logic [WIDTH-1:0] out_d;
  assign out = in1 ^ in2;
  assign out_d = out;
  // registered copy of the XOR result
  always_ff @(posedge clk) out_q <= rst ? '0 : out_d;
  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_d != out_q),
    .cnt (tog_cnt)
  );
endmodule

// File: tb/tb_xor_gate_primitive.sv
// tb_xor_gate_primitive: randomized and directed checks against a behavioural model
module tb_xor_gate_primitive;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] a1, a2, ao, aq;
  logic [15:0] ac;
  logic b1, b2, bo, bq;
  logic [3:0] bc;
  logic [3:0] m_aq;
  int m_ac;
  logic m_bq;
  int m_bc;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  xor_gate_primitive #(.WIDTH(4)) u_dut (
    .clk(clk), .rst(rst), .out(ao), .in1(a1), .in2(a2), .out_q(aq), .tog_cnt(ac)
  );
  xor_gate_primitive #(.WIDTH(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .out(bo), .in1(b1), .in2(b2), .out_q(bq), .tog_cnt(bc)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] xor_ref(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] r;
    for (int i = 0; i < 4; i++)
      r[i] = (x[i] === 1'bx || x[i] === 1'bz || y[i] === 1'bx || y[i] === 1'bz) ? 1'bx :
             (x[i] == y[i]) ? 1'b0 : 1'b1;
    return r;
  endfunction
  task automatic drive(input logic [3:0] x, input logic [3:0] y, input logic p, input logic q);
    logic [3:0] e;
    a1 = x; a2 = y; b1 = p; b2 = q;
    #1;
    e = xor_ref(x, y);
    check("out_a", {28'd0, ao}, {28'd0, e});
    e = xor_ref({3'd0, p}, {3'd0, q});
    check("out_b", {31'd0, bo}, {31'd0, e[0]});
  endtask
  task automatic tick(input bit chk_cnt);
    logic [3:0] na;
    logic [3:0] nb;
    logic r;
    na = xor_ref(a1, a2);
    nb = xor_ref({3'd0, b1}, {3'd0, b2});
    r = rst;
    @(posedge clk);
    if (r) begin
      m_aq = '0; m_ac = 0; m_bq = 1'b0; m_bc = 0;
    end else begin
      if (na !== m_aq) m_ac = (m_ac + 1 > 65535) ? 65535 : m_ac + 1;
      if (nb[0] !== m_bq) m_bc = (m_bc + 1 > 15) ? 15 : m_bc + 1;
      m_aq = na;
      m_bq = nb[0];
    end
    #1;
    check("out_q_a", {28'd0, aq}, {28'd0, m_aq});
    check("out_q_b", {31'd0, bq}, {31'd0, m_bq});
    if (chk_cnt) begin
      check("tog_cnt_a", {16'd0, ac}, m_ac);
      check("tog_cnt_b", {28'd0, bc}, m_bc);
    end
  endtask
  initial begin
    rst = 1'b1;
    drive(4'h0, 4'h0, 1'b0, 1'b0);
    tick(1);
    tick(1);
    check("reset_q", {28'd0, aq}, 32'd0);
    check("reset_cnt", {16'd0, ac}, 32'd0);
    rst = 1'b0;
    tick(1);
    for (int k = 0; k < 4; k++) begin
      drive(4'(k), 4'(k >> 1), k[0], k[1]);
      tick(1);
    end
    drive(4'h0, 4'h0, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      drive(4'($urandom), 4'($urandom), k[0], 1'b1);
      tick(1);
    end
    check("sat_hold", {28'd0, bc}, 32'd15);
    for (int k = 0; k < 200; k++) begin
      drive(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      rst = ($urandom_range(0, 19) == 0);
      tick(1);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      drive(k[0] ? 4'h0 : 4'h1, 4'h0, 1'b0, 1'b0);
      tick(1);
    end
    check("mid_q", {28'd0, aq}, 32'd1);
    check("mid_cnt", {16'd0, ac}, 32'd7);
    rst = 1'b1;
    drive(4'h5, 4'h3, 1'b1, 1'b0);
    tick(1);
    check("mid_rst_q", {28'd0, aq}, 32'd0);
    check("mid_rst_cnt", {16'd0, ac}, 32'd0);
    check("mid_rst_out", {28'd0, ao}, 32'd6);
    rst = 1'b0;
    tick(1);
    drive(4'bxxxx, 4'h0, 1'bx, 1'b0);
    tick(0);
    rst = 1'b1;
    drive(4'h0, 4'h0, 1'b0, 1'b0);
    tick(1);
    rst = 1'b0;
    tick(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
